// File: rtl/store_pkg.sv
// Shared definitions for the store unit: FSM states, funct3 encodings,
// byte-lane strobe patterns and a funct3 legality helper.
// Configuration macro used elsewhere in this slice: STORE_MISALIGN_TRAP_EN.
package store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [3:0] STRB_NONE    = 4'b0000;
  localparam logic [3:0] STRB_BYTE    = 4'b0001;
  localparam logic [3:0] STRB_HALF_LO = 4'b0011;
  localparam logic [3:0] STRB_HALF_HI = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // Only byte, half and word stores exist; every other funct3 is rejected.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: replicates store data across byte lanes
// and builds the byte-lane strobe from funct3 and the low address bits.
// Macro STORE_MISALIGN_TRAP_EN: when defined, flags misaligned sh/sw;
// otherwise misaligned is tied low and the low address bits are ignored
// for halfword/word stores.
module store_align
  import store_pkg::*;
(
  input  logic [2:0]  fu3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned
);

  logic [31:0] byte_rep;
  logic [31:0] half_rep;

  // Copy the low byte into every lane so any strobe picks the right value.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_rep
    assign byte_rep[gi*8 +: 8] = data[7:0];
  end

  // Copy the low halfword into both halves.
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_rep
    assign half_rep[gi*16 +: 16] = data[15:0];
  end

  // Select replicated data and lane enables by access size.
  always_comb begin
    wdata = 32'd0;
    wstrb = STRB_NONE;
    case (fu3)
      F3_SB: begin
        wdata = byte_rep;
        wstrb = STRB_BYTE << addr_lo;
      end
      F3_SH: begin
        wdata = half_rep;
        wstrb = addr_lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
      end
      F3_SW: begin
        wdata = data;
        wstrb = STRB_WORD;
      end
      default: begin
        wdata = 32'd0;
        wstrb = STRB_NONE;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    misaligned = 1'b0;
    if (fu3 == F3_SH) misaligned = addr_lo[0];
    else if (fu3 == F3_SW) misaligned = (addr_lo != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts a single store request, issues one aligned memory
// write with byte strobes and waits for mem_ack, aborting with err after
// ACK_TIMEOUT request cycles. Illegal funct3 (and, with macro
// STORE_MISALIGN_TRAP_EN defined, misaligned sh/sw) complete immediately
// with err and no memory request.
module store_unit
  import store_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in_store,
  input  logic [2:0]  fu3,
  input  logic [31:0] addr,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Counter value of the last request cycle before abort.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [29:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        err_reg, err_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic [31:0] align_wdata;
  logic [3:0]  align_wstrb;
  logic        align_misaligned;

  store_align u_align (
    .fu3        (fu3),
    .addr_lo    (addr[1:0]),
    .data       (int_in_store),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .misaligned (align_misaligned)
  );

  // State and captured-request registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: capture on start, wait for ack or timeout, pulse done.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          addr_next  = addr[31:2];
          wdata_next = align_wdata;
          wstrb_next = align_wstrb;
          cnt_next   = '0;
          if (!f3_legal(fu3) || align_misaligned) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = ST_REQ;
            err_next   = 1'b0;
          end
        end
      end
      ST_REQ: begin
        // Ack takes priority over the terminal count.
        if (mem_ack) begin
          state_next = ST_DONE;
          err_next   = 1'b0;
        end else if (cnt_reg == TO_LAST) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_req   = (state_reg == ST_REQ);
  assign mem_addr  = {addr_reg, 2'b00};
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = mem_req ? wstrb_reg : STRB_NONE;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err       = done & err_reg;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit (ACK_TIMEOUT = 16).
// Expectations for the misaligned word store follow STORE_MISALIGN_TRAP_EN.
module tb_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] int_in_store;
  logic [2:0]  fu3;
  logic [31:0] addr;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int n;

  store_unit #(.ACK_TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .int_in_store (int_in_store),
    .fu3          (fu3),
    .addr         (addr),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    fu3 = f;
    addr = a;
    int_in_store = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    int_in_store = 32'd0;
    fu3 = 3'd0;
    addr = 32'd0;
    mem_ack = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // sb to 0x103, ack in the third request cycle
    issue(3'd0, 32'h0000_0103, 32'h0000_00A5);
    check("sb_req", 32'(mem_req), 32'd1);
    check("sb_busy", 32'(busy), 32'd1);
    check("sb_addr", mem_addr, 32'h0000_0100);
    check("sb_wstrb", 32'(mem_wstrb), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    tick();
    check("sb_req2", 32'(mem_req), 32'd1);
    check("sb_done_early", 32'(done), 32'd0);
    tick();
    check("sb_wstrb3", 32'(mem_wstrb), 32'h8);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_done", 32'(done), 32'd1);
    check("sb_err", 32'(err), 32'd0);
    check("sb_req_off", 32'(mem_req), 32'd0);
    check("sb_wstrb_off", 32'(mem_wstrb), 32'd0);
    tick();
    check("sb_done_pulse", 32'(done), 32'd0);
    check("sb_idle", 32'(busy), 32'd0);
    $display("txn sb addr=0x103 data=0xa5 done");

    // sh to 0x202, ack in the first request cycle
    issue(3'd1, 32'h0000_0202, 32'h1234_BEEF);
    check("sh_req", 32'(mem_req), 32'd1);
    check("sh_addr", mem_addr, 32'h0000_0200);
    check("sh_wstrb", 32'(mem_wstrb), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_done", 32'(done), 32'd1);
    check("sh_err", 32'(err), 32'd0);
    tick();
    $display("txn sh addr=0x202 data=0x1234beef done");

    // Extra lane patterns: sb at offset 2, sh at offset 0
    issue(3'd0, 32'h0000_0002, 32'h0000_0077);
    check("sb2_wstrb", 32'(mem_wstrb), 32'h4);
    check("sb2_wdata", mem_wdata, 32'h7777_7777);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    issue(3'd1, 32'h0000_0010, 32'hAAAA_5678);
    check("sh0_wstrb", 32'(mem_wstrb), 32'h3);
    check("sh0_wdata", mem_wdata, 32'h5678_5678);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    $display("txn sb/sh lane patterns done");

    // sw to misaligned 0x301
    issue(3'd2, 32'h0000_0301, 32'hCAFE_F00D);
`ifdef STORE_MISALIGN_TRAP_EN
    check("swm_req", 32'(mem_req), 32'd0);
    check("swm_done", 32'(done), 32'd1);
    check("swm_err", 32'(err), 32'd1);
    tick();
`else
    check("swm_req", 32'(mem_req), 32'd1);
    check("swm_addr", mem_addr, 32'h0000_0300);
    check("swm_wstrb", 32'(mem_wstrb), 32'hF);
    check("swm_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("swm_done", 32'(done), 32'd1);
    check("swm_err", 32'(err), 32'd0);
    tick();
`endif
    $display("txn sw addr=0x301 done");

    // sw with no ack: 16 request cycles then timeout; start mid-request ignored
    issue(3'd2, 32'h0000_0400, 32'hDEAD_BEEF);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
      tick();
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_done", 32'(done), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_wstrb", 32'(mem_wstrb), 32'd0);
    tick();
    check("to_no_queue", 32'(busy), 32'd0);
    check("to_done_pulse", 32'(done), 32'd0);
    $display("txn sw timeout req_cycles=%0d", n);

    // Ack arrives on the terminal request cycle: ack wins
    issue(3'd2, 32'h0000_0500, 32'h0102_0304);
    for (int i = 0; i < 15; i++) tick();
    check("term_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("term_done", 32'(done), 32'd1);
    check("term_err", 32'(err), 32'd0);
    tick();
    $display("txn sw ack on terminal cycle done");

    // Reset in the second request cycle abandons the store
    issue(3'd2, 32'h0000_0600, 32'h1111_2222);
    tick();
    check("rr_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_req", 32'(mem_req), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_addr", mem_addr, 32'd0);
    check("rr_done", 32'(done), 32'd0);
    tick();
    check("rr_done_after", 32'(done), 32'd0);
    $display("txn sw reset mid-request abandoned");

    // Illegal funct3
    issue(3'd3, 32'h0000_0700, 32'h3333_4444);
    check("ill_req", 32'(mem_req), 32'd0);
    check("ill_done", 32'(done), 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_wstrb", 32'(mem_wstrb), 32'd0);
    tick();
    check("ill_idle", 32'(busy), 32'd0);
    $display("txn illegal fu3=3 done");

    // Stray ack while idle has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_done", 32'(done), 32'd0);
    check("idle_ack_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, max cycles in REQ awaiting mem_ack before abort (range 2..255).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle store request; sampled only in IDLE.
REQ-005 int_in_store  input  32  rs2 store data.
REQ-006 fu3  input  3  funct3: 0=sb, 1=sh, 2=sw; others illegal.
REQ-007 addr  input  32  effective byte address.
REQ-008 mem_ack  input  1  memory write accept.
REQ-009 mem_req  output  1  write request to memory.
REQ-010 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-011 mem_wdata  output  32  lane-replicated write data.
REQ-012 mem_wstrb  output  4  byte-lane write enables.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  valid with done; high on illegal fu3, misalign, or timeout.

Function
REQ-016 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-017 IDLE with start=1: register fu3, addr, data, computed wdata/wstrb; next state REQ (mem_req high cycle N+1 after start at N); illegal fu3 goes DONE with err=1, no request.
REQ-018 sb: wstrb = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
REQ-019 sh: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
REQ-020 sw: wstrb = 4'b1111, wdata = data.
REQ-021 REQ: mem_req=1, mem_addr/mem_wdata/mem_wstrb held stable until mem_ack sampled high; then DONE with err=0.
REQ-022 Timeout counter cleared on entry to REQ, increments each REQ cycle without ack; at ACK_TIMEOUT-1 without ack go DONE with err=1, mem_req drops.
REQ-023 mem_ack and timeout terminal count in same cycle: ack wins, err=0.
REQ-024 DONE: done=1 exactly one cycle, mem_req=0, return to IDLE; start during DONE or REQ ignored (no queuing).
REQ-025 mem_ack outside REQ ignored.
REQ-026 mem_wstrb = 0 whenever mem_req = 0.

Reset
REQ-027 reset overrides all: next edge state IDLE, mem_req/done/err/busy = 0, mem_wstrb = 0, mem_addr/mem_wdata = 0, counter = 0.
REQ-028 reset during REQ abandons the store; no done pulse generated.

Configuration
REQ-029 Macro STORE_MISALIGN_TRAP_EN: when defined, sh with addr[0]=1 or sw with addr[1:0]!=0 issues no request and goes DONE with err=1.
REQ-030 Without the macro: misalignment not detected; sh ignores addr[0], sw ignores addr[1:0], store proceeds normally.

Structure
REQ-031 Shared package store_pkg holds FSM state enum, funct3 constants (F3_SB, F3_SH, F3_SW) and strobe constants.
REQ-032 One combinational sub-module store_align (fu3, addr[1:0], data -> wdata, wstrb, misaligned) instantiated once.

Verification
REQ-033 sb data=0x000000A5, addr=0x103 -> mem_addr 0x100, wstrb 1000, wdata 0xA5A5A5A5; ack after 3 cycles -> done=1, err=0.
REQ-034 sh data=0x1234BEEF, addr=0x202, ack same cycle req rises -> wstrb 1100, wdata 0xBEEFBEEF, done next cycle.
REQ-035 sw addr=0x301 -> with macro: no mem_req, done+err=1; without macro: wstrb 1111, mem_addr 0x300, store completes.
REQ-036 sw, mem_ack held low, ACK_TIMEOUT=16 -> mem_req high 16 cycles, then done+err=1; ack on terminal cycle -> err=0.
REQ-037 reset asserted second cycle of REQ -> mem_req low next edge, no done; fu3=3'd3 -> done+err=1, no mem_req; start while busy ignored.
